// File: rtl/datapath_pkg.sv
// Shared types and constants for the multi-cycle integer datapath.
// Opcodes, condition-code encodings and instruction field positions.
package datapath_pkg;

    typedef enum logic [2:0] {
        FETCH,
        DECODE,
        EXEC,
        MEM,
        WB,
        HALT
    } state_t;

    localparam logic [4:0] OP_BR   = 5'h00;
    localparam logic [4:0] OP_ADD  = 5'h01;
    localparam logic [4:0] OP_JSR  = 5'h04;
    localparam logic [4:0] OP_AND  = 5'h05;
    localparam logic [4:0] OP_LDW  = 5'h06;
    localparam logic [4:0] OP_STW  = 5'h07;
    localparam logic [4:0] OP_MOV  = 5'h09;
    localparam logic [4:0] OP_JMP  = 5'h0C;
    localparam logic [4:0] OP_JSRR = 5'h14;

    localparam logic [2:0] CC_P = 3'b100;
    localparam logic [2:0] CC_Z = 3'b010;
    localparam logic [2:0] CC_N = 3'b001;

    localparam int OP_HI    = 31;
    localparam int OP_LO    = 27;
    localparam int NZP_HI   = 26;
    localparam int NZP_LO   = 24;
    localparam int IMMF_BIT = 24;
    localparam int DST_HI   = 23;
    localparam int DST_LO   = 20;
    localparam int SRC1_HI  = 19;
    localparam int SRC1_LO  = 16;
    localparam int SRC2_HI  = 11;
    localparam int SRC2_LO  = 8;
    localparam int IMM_HI   = 15;
    localparam int IMM_LO   = 0;
    localparam int LINK_REG = 7;

endpackage

// File: rtl/datapath_alu.sv
// Combinational ADD/AND/MOV unit plus write-back value and CC generation.
// LDW passes the load data through so CC is derived from the written value.
module datapath_alu
    import datapath_pkg::*;
#(
    parameter int DATA_W = 16
) (
    input  logic [4:0]        op,
    input  logic              use_imm,
    input  logic [DATA_W-1:0] src1,
    input  logic [DATA_W-1:0] src2,
    input  logic [DATA_W-1:0] imm,
    input  logic [DATA_W-1:0] load_data,
    output logic [DATA_W-1:0] result,
    output logic [2:0]        cc
);

    logic [DATA_W-1:0] opnd;

    assign opnd = use_imm ? imm : src2;

    always_comb begin
        result = '0;
        case (op)
            OP_ADD:  result = src1 + opnd;
            OP_AND:  result = src1 & opnd;
            OP_MOV:  result = opnd;
            OP_LDW:  result = load_data;
            default: result = '0;
        endcase
    end

    always_comb begin
        cc = CC_P;
        if (result[DATA_W-1])
            cc = CC_N;
        else if (result == '0)
            cc = CC_Z;
    end

endmodule

// File: rtl/multicycle_datapath.sv
// Multi-cycle FETCH/DECODE/EXEC/MEM/WB datapath with req/ack memories.
// Define DATAPATH_BUS_TIMEOUT_EN to halt on a memory wait of TIMEOUT_CYC.
module multicycle_datapath
    import datapath_pkg::*;
#(
    parameter int DATA_W      = 16,
    parameter int NUM_REGS    = 8,
    parameter int PC_W        = 16,
    parameter int TIMEOUT_CYC = 64
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              lock,
    output logic              imem_req,
    output logic [PC_W-1:0]   imem_addr,
    input  logic              imem_ack,
    input  logic [31:0]       imem_rdata,
    output logic              dmem_req,
    output logic              dmem_we,
    output logic [DATA_W-1:0] dmem_addr,
    output logic [DATA_W-1:0] dmem_wdata,
    input  logic              dmem_ack,
    input  logic [DATA_W-1:0] dmem_rdata,
    output logic [PC_W-1:0]   pc_out,
    output logic [2:0]        cc_out,
    output logic              retire,
    output logic              halted
);

    localparam int RI_W = $clog2(NUM_REGS);
    localparam logic [PC_W-1:0] ALIGN = {{(PC_W-2){1'b1}}, 2'b00};

    state_t state, state_nx;

    logic [31:0]       ir;
    logic [PC_W-1:0]   pc;
    logic [2:0]        cc;
    logic [DATA_W-1:0] regs [NUM_REGS];
    logic [DATA_W-1:0] s1_q, s2_q, sd_q, ea_q, mdr;
    logic              br_take;
    logic              timeout;

    logic [4:0]        op;
    logic [RI_W-1:0]   dst_i, s1_i, s2_i;
    logic [DATA_W-1:0] imm_ext;
    logic [PC_W-1:0]   off_pc, pc_plus4, pc_rel, pc_reg, pc_nx;
    logic [DATA_W-1:0] alu_res;
    logic [2:0]        alu_cc;
    logic              wr_dst, link, is_mem;

    assign op      = ir[OP_HI:OP_LO];
    assign dst_i   = RI_W'(ir[DST_HI:DST_LO]);
    assign s1_i    = RI_W'(ir[SRC1_HI:SRC1_LO]);
    assign s2_i    = RI_W'(ir[SRC2_HI:SRC2_LO]);
    assign imm_ext = DATA_W'($signed(ir[IMM_HI:IMM_LO]));
    assign off_pc  = PC_W'($signed(ir[IMM_HI:IMM_LO])) << 2;

    assign pc_plus4 = (pc + PC_W'(4)) & ALIGN;
    assign pc_rel   = (pc + off_pc) & ALIGN;
    assign pc_reg   = PC_W'(s1_q) & ALIGN;

    assign wr_dst = (op == OP_ADD) || (op == OP_AND) ||
                    (op == OP_MOV) || (op == OP_LDW);
    assign link   = (op == OP_JSR) || (op == OP_JSRR);
    assign is_mem = (op == OP_LDW) || (op == OP_STW);

    always_comb begin
        pc_nx = pc_plus4;
        case (op)
            OP_BR:   pc_nx = br_take ? pc_rel : pc_plus4;
            OP_JSR:  pc_nx = pc_rel;
            OP_JMP:  pc_nx = pc_reg;
            OP_JSRR: pc_nx = pc_reg;
            default: pc_nx = pc_plus4;
        endcase
    end

    datapath_alu #(
        .DATA_W (DATA_W)
    ) u_alu (
        .op        (op),
        .use_imm   (ir[IMMF_BIT]),
        .src1      (s1_q),
        .src2      (s2_q),
        .imm       (imm_ext),
        .load_data (mdr),
        .result    (alu_res),
        .cc        (alu_cc)
    );

`ifdef DATAPATH_BUS_TIMEOUT_EN
    localparam int TW = $clog2(TIMEOUT_CYC + 1);

    logic [TW-1:0] wcnt;
    logic          wait_on, ack_now;

    assign wait_on = ((state == FETCH) && lock) || (state == MEM);
    assign ack_now = (state == FETCH) ? imem_ack : dmem_ack;
    assign timeout = wait_on && !ack_now && (wcnt == TW'(TIMEOUT_CYC - 1));
    assign halted  = (state == HALT);

    always_ff @(posedge clk) begin
        if (reset || !wait_on || ack_now)
            wcnt <= '0;
        else
            wcnt <= wcnt + 1'b1;
    end
`else
    logic unused_timeout_cfg;

    assign unused_timeout_cfg = (TIMEOUT_CYC > 0);
    assign timeout = 1'b0;
    assign halted  = 1'b0;
`endif

    always_comb begin
        state_nx   = state;
        imem_req   = 1'b0;
        dmem_req   = 1'b0;
        dmem_we    = 1'b0;
        dmem_addr  = '0;
        dmem_wdata = '0;
        retire     = 1'b0;
        case (state)
            FETCH: begin
                if (lock) begin
                    imem_req = 1'b1;
                    if (imem_ack)
                        state_nx = DECODE;
                    else if (timeout)
                        state_nx = HALT;
                end
            end
            DECODE: state_nx = EXEC;
            EXEC:   state_nx = is_mem ? MEM : WB;
            MEM: begin
                dmem_req   = 1'b1;
                dmem_we    = (op == OP_STW);
                dmem_addr  = ea_q;
                dmem_wdata = sd_q;
                if (dmem_ack)
                    state_nx = WB;
                else if (timeout)
                    state_nx = HALT;
            end
            WB: begin
                retire   = 1'b1;
                state_nx = FETCH;
            end
            HALT:    state_nx = HALT;
            default: state_nx = FETCH;
        endcase
        // Handshakes drop in the reset cycle so a stalled access is abandoned.
        if (reset) begin
            imem_req = 1'b0;
            dmem_req = 1'b0;
            dmem_we  = 1'b0;
            retire   = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state   <= FETCH;
            pc      <= '0;
            cc      <= CC_Z;
            ir      <= '0;
            s1_q    <= '0;
            s2_q    <= '0;
            sd_q    <= '0;
            ea_q    <= '0;
            mdr     <= '0;
            br_take <= 1'b0;
            for (int i = 0; i < NUM_REGS; i++)
                regs[i] <= '0;
        end else begin
            state <= state_nx;
            case (state)
                FETCH: begin
                    if (lock && imem_ack)
                        ir <= imem_rdata;
                end
                DECODE: begin
                    s1_q <= regs[s1_i];
                    s2_q <= regs[s2_i];
                    sd_q <= regs[dst_i];
                end
                EXEC: begin
                    ea_q    <= s1_q + imm_ext;
                    br_take <= |(ir[NZP_HI:NZP_LO] & {cc[0], cc[1], cc[2]});
                end
                MEM: begin
                    if (dmem_ack && (op == OP_LDW))
                        mdr <= dmem_rdata;
                end
                WB: begin
                    pc <= pc_nx;
                    if (wr_dst) begin
                        regs[dst_i] <= alu_res;
                        cc          <= alu_cc;
                    end
                    if (link)
                        regs[RI_W'(LINK_REG)] <= DATA_W'(pc_plus4);
                end
                default: ;
            endcase
        end
    end

    assign imem_addr = pc;
    assign pc_out    = pc;
    assign cc_out    = cc;

endmodule
